// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Two-requester front end for one shared combinational 4-bit ALU.
//   A granted request is captured, presented to the ALU for one cycle,
//   and the ALU result is registered and held for the granted requester
//   until that requester consumes it.
//
// Parameters
//   FIXED_PRIO : 0 = round-robin on ties, 1 = requester 0 always wins ties.
//
// Ports
//   clk, reset                   : clock, synchronous active-high reset
//   reqN_valid / reqN_ready      : request handshake for requester N
//   reqN_op, reqN_a, reqN_b      : ALU control code and operands
//   rspN_valid / rspN_ready      : response handshake for requester N
//   rsp_y, rsp_c4                : registered result, shared by both ports
//   alu_a, alu_b, alu_cont       : drive the shared ALU
//   alu_y, alu_c4                : combinational result from the shared ALU
//   busy                         : high whenever an operation is in flight
module alu_arbiter #(
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic       req1_valid,
  output logic       req0_ready,
  output logic       req1_ready,
  input  logic [2:0] req0_op,
  input  logic [2:0] req1_op,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  output logic       rsp0_valid,
  output logic       rsp1_valid,
  input  logic       rsp0_ready,
  input  logic       rsp1_ready,
  output logic [3:0] rsp_y,
  output logic       rsp_c4,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_cont,
  input  logic [3:0] alu_y,
  input  logic       alu_c4,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic [3:0] y_q, y_d;
  logic       c4_q, c4_d;
  // Holds the requester of the operation in flight; the same register
  // doubles as the round-robin history, since both update only on accept.
  logic       last_grant_q, last_grant_d;

  logic grant_valid;
  logic grant_idx;
  logic accept;
  logic rsp_ready_sel;

  always_comb begin
    grant_valid = req0_valid | req1_valid;
    grant_idx   = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_idx = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant_q;
    end else if (req1_valid) begin
      grant_idx = 1'b1;
    end
  end

  assign req0_ready = (state_q == IDLE) && !reset && grant_valid && (grant_idx == 1'b0);
  assign req1_ready = (state_q == IDLE) && !reset && grant_valid && (grant_idx == 1'b1);
  assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  assign rsp_ready_sel = last_grant_q ? rsp1_ready : rsp0_ready;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    y_d          = y_q;
    c4_d         = c4_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d      = EXEC;
          last_grant_d = grant_idx;
          op_d         = grant_idx ? req1_op : req0_op;
          a_d          = grant_idx ? req1_a  : req0_a;
          b_d          = grant_idx ? req1_b  : req0_b;
        end
      end
      EXEC: begin
        state_d = RESP;
        y_d     = alu_y;
        c4_d    = alu_c4;
      end
      RESP: begin
        if (rsp_ready_sel) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      y_q          <= '0;
      c4_q         <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      y_q          <= y_d;
      c4_q         <= c4_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_cont   = op_q;
  assign rsp_y      = y_q;
  assign rsp_c4     = c4_q;
  assign rsp0_valid = (state_q == RESP) && !last_grant_q;
  assign rsp1_valid = (state_q == RESP) &&  last_grant_q;
  assign busy       = (state_q != IDLE);

endmodule
